// File: rtl/fft_pkg.sv
// Shared types and elaboration-time helpers for the iterative radix-2 FFT.
// The complex container is wide enough for any supported twiddle width.
package fft_pkg;

  localparam int  CPLX_W = 32;
  localparam real PI     = 3.14159265358979323846;

  typedef struct packed {
    logic signed [CPLX_W-1:0] re;
    logic signed [CPLX_W-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_UNLOAD  = 2'd2
  } state_t;

  function automatic int clog2(input int unsigned value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned bitrev(input int unsigned value, input int unsigned bits);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (i < bits) r = r | (((value >> i) & 32'd1) << (bits - 1 - i));
    end
    return r;
  endfunction

  // cos and sin of 2*pi*k/n scaled so that +1.0 maps to 2^(tw-1)-1, rounded
  // to nearest; the sign of the imaginary part is applied by the user
  function automatic cplx_t twiddle(input int k, input int n, input int tw);
    cplx_t w;
    real   ang;
    real   scale;
    ang   = 2.0 * PI * real'(k) / real'(n);
    scale = real'((64'd1 << (tw - 1)) - 64'd1);
    w.re  = CPLX_W'($rtoi($floor($cos(ang) * scale + 0.5)));
    w.im  = CPLX_W'($rtoi($floor($sin(ang) * scale + 0.5)));
    return w;
  endfunction

endpackage

// File: rtl/fft_bfly_r2.sv
// Radix-2 DIT butterfly, two register stages.
// Stage 1 forms the rounded twiddle product t = B*W; stage 2 forms
// (A+t)>>>1 and (A-t)>>>1. Intermediates are kept wide enough that nothing
// wraps before the final truncation back to DW bits.
module fft_bfly_r2 #(
  parameter int DW = 16,
  parameter int TW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] a_re,
  input  logic signed [DW-1:0] a_im,
  input  logic signed [DW-1:0] b_re,
  input  logic signed [DW-1:0] b_im,
  input  logic signed [TW-1:0] w_re,
  input  logic signed [TW-1:0] w_im,
  output logic                 out_valid,
  output logic signed [DW-1:0] ao_re,
  output logic signed [DW-1:0] ao_im,
  output logic signed [DW-1:0] bo_re,
  output logic signed [DW-1:0] bo_im
);

  localparam int PW = DW + TW + 1;
  localparam int XW = DW + 2;
  localparam int SW = DW + 3;
  localparam logic signed [PW-1:0] RND = PW'(1) << (TW - 2);

  logic signed [PW-1:0] p_re, p_im;
  logic signed [DW-1:0] a_re_q, a_im_q;
  logic signed [XW-1:0] t_re_q, t_im_q;
  logic                 v_q;
  logic signed [SW-1:0] s_re_p, s_im_p, s_re_m, s_im_m;

  assign p_re = PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(w_im) + RND;
  assign p_im = PW'(b_re) * PW'(w_im) + PW'(b_im) * PW'(w_re) + RND;

  // stage 1: rounded product and aligned A operand
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q    <= 1'b0;
      a_re_q <= '0;
      a_im_q <= '0;
      t_re_q <= '0;
      t_im_q <= '0;
    end else begin
      v_q    <= in_valid;
      a_re_q <= a_re;
      a_im_q <= a_im;
      t_re_q <= XW'(p_re >>> (TW - 1));
      t_im_q <= XW'(p_im >>> (TW - 1));
    end
  end

  assign s_re_p = SW'(a_re_q) + SW'(t_re_q);
  assign s_im_p = SW'(a_im_q) + SW'(t_im_q);
  assign s_re_m = SW'(a_re_q) - SW'(t_re_q);
  assign s_im_m = SW'(a_im_q) - SW'(t_im_q);

  // stage 2: sum/difference halved, floor rounding
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      ao_re     <= '0;
      ao_im     <= '0;
      bo_re     <= '0;
      bo_im     <= '0;
    end else begin
      out_valid <= v_q;
      ao_re     <= DW'(s_re_p >>> 1);
      ao_im     <= DW'(s_im_p >>> 1);
      bo_re     <= DW'(s_re_m >>> 1);
      bo_im     <= DW'(s_im_m >>> 1);
    end
  end

endmodule

// File: rtl/fft_radix2_iter.sv
// Iterative in-place radix-2 DIT FFT, one butterfly per cycle.
// Optional macro FFT_IFFT_EN adds the 'inverse' input (conjugated twiddles).
//
//   state      | meaning
//   ST_LOAD    | accept N samples, store at bit-reversed address
//   ST_COMPUTE | log2(N) stages of N/2 butterflies + 2 drain cycles each
//   ST_UNLOAD  | present bins 0..N-1 under valid/ready
module fft_radix2_iter import fft_pkg::*; #(
  parameter int N  = 16,
  parameter int DW = 16,
  parameter int TW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef FFT_IFFT_EN
  input  logic                 inverse,
`endif
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_re,
  input  logic signed [DW-1:0] in_im,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_re,
  output logic signed [DW-1:0] out_im,
  output logic                 out_last,
  output logic                 busy
);

  localparam int L         = clog2(N);
  localparam int AW        = L;
  localparam int TKW       = AW - 1;
  localparam int HALF      = N / 2;
  localparam int STAGE_LEN = HALF + 2;

  state_t               state;
  logic [AW-1:0]        n_cnt, cnt, k_cnt;
  logic [3:0]           stage;
  logic                 inv_r;
  logic                 in_fire;

  logic signed [DW-1:0] buf_re [N];
  logic signed [DW-1:0] buf_im [N];
  logic signed [TW-1:0] rom_cos [HALF];
  logic signed [TW-1:0] rom_sin [HALF];

  logic                 issue;
  logic [AW-1:0]        half_mask, a_addr, b_addr;
  logic [TKW-1:0]       tw_k;
  logic signed [TW-1:0] w_re, w_im;
  logic [AW-1:0]        a_addr_d1, b_addr_d1, a_addr_d2, b_addr_d2;

  logic                 wb_valid;
  logic signed [DW-1:0] wb_a_re, wb_a_im, wb_b_re, wb_b_im;

  for (genvar g = 0; g < HALF; g++) begin : g_rom
    localparam cplx_t TWV = twiddle(g, N, TW);
    assign rom_cos[g] = TWV.re[TW-1:0];
    assign rom_sin[g] = TWV.im[TW-1:0];
  end

  assign in_fire = (state == ST_LOAD) && in_valid && in_ready;

`ifdef FFT_IFFT_EN
  // direction is latched from the first sample of each frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) inv_r <= 1'b0;
    else if (in_fire && (n_cnt == '0)) inv_r <= inverse;
  end
`else
  assign inv_r = 1'b0;
`endif

  // butterfly i of stage s: pair spacing 2^s, twiddle index j*N/2^(s+1)
  always_comb begin
    issue     = (state == ST_COMPUTE) && (cnt < AW'(HALF));
    half_mask = (AW'(1) << stage) - AW'(1);
    a_addr    = ((cnt >> stage) << (stage + 4'd1)) | (cnt & half_mask);
    b_addr    = a_addr | (AW'(1) << stage);
    tw_k      = TKW'((cnt & half_mask) << (4'(L - 1) - stage));
    w_re      = rom_cos[tw_k];
    w_im      = inv_r ? rom_sin[tw_k] : -rom_sin[tw_k];
  end

  fft_bfly_r2 #(.DW(DW), .TW(TW)) u_bfly (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (issue),
    .a_re      (buf_re[a_addr]),
    .a_im      (buf_im[a_addr]),
    .b_re      (buf_re[b_addr]),
    .b_im      (buf_im[b_addr]),
    .w_re      (w_re),
    .w_im      (w_im),
    .out_valid (wb_valid),
    .ao_re     (wb_a_re),
    .ao_im     (wb_a_im),
    .bo_re     (wb_b_re),
    .bo_im     (wb_b_im)
  );

  // write-back addresses travel alongside the butterfly pipeline
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_addr_d1 <= '0;
      b_addr_d1 <= '0;
      a_addr_d2 <= '0;
      b_addr_d2 <= '0;
    end else begin
      a_addr_d1 <= a_addr;
      b_addr_d1 <= b_addr;
      a_addr_d2 <= a_addr_d1;
      b_addr_d2 <= b_addr_d1;
    end
  end

  // sample buffer: bit-reversed load, in-place butterfly write-back
  always_ff @(posedge clk) begin
    if (in_fire) begin
      buf_re[AW'(bitrev(32'(n_cnt), L))] <= in_re;
      buf_im[AW'(bitrev(32'(n_cnt), L))] <= in_im;
    end else if (wb_valid) begin
      buf_re[a_addr_d2] <= wb_a_re;
      buf_im[a_addr_d2] <= wb_a_im;
      buf_re[b_addr_d2] <= wb_b_re;
      buf_im[b_addr_d2] <= wb_b_im;
    end
  end

  // frame sequencing with registered handshake and output data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_LOAD;
      n_cnt     <= '0;
      cnt       <= '0;
      stage     <= '0;
      k_cnt     <= '0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (in_fire) begin
            if (n_cnt == AW'(N - 1)) begin
              n_cnt    <= '0;
              cnt      <= '0;
              stage    <= '0;
              in_ready <= 1'b0;
              busy     <= 1'b1;
              state    <= ST_COMPUTE;
            end else begin
              n_cnt <= n_cnt + AW'(1);
            end
          end
        end
        ST_COMPUTE: begin
          if (cnt == AW'(STAGE_LEN - 1)) begin
            cnt <= '0;
            if (stage == 4'(L - 1)) begin
              k_cnt <= '0;
              state <= ST_UNLOAD;
            end else begin
              stage <= stage + 4'd1;
            end
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        ST_UNLOAD: begin
          if (!out_valid) begin
            out_re    <= buf_re[k_cnt];
            out_im    <= buf_im[k_cnt];
            out_last  <= (k_cnt == AW'(N - 1));
            out_valid <= 1'b1;
          end else if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              k_cnt     <= '0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
              state     <= ST_LOAD;
            end else begin
              out_re   <= buf_re[k_cnt + AW'(1)];
              out_im   <= buf_im[k_cnt + AW'(1)];
              out_last <= ((k_cnt + AW'(1)) == AW'(N - 1));
              k_cnt    <= k_cnt + AW'(1);
            end
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_radix2_iter.sv
// Self-checking bench for fft_radix2_iter (N=16). Expected bins come from a
// textbook in-place Cooley-Tukey model with the same fixed-point rounding,
// plus fixed values for the impulse and constant frames.
module tb_fft_radix2_iter;

  localparam int  N   = 16;
  localparam int  DW  = 16;
  localparam int  TW  = 16;
  localparam int  L   = 4;
  localparam int  LAT = L * (N / 2 + 2) + 1;
  localparam real PI  = 3.14159265358979323846;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic signed [DW-1:0] in_re, in_im, out_re, out_im;
`ifdef FFT_IFFT_EN
  logic                 inverse;
`endif

  int n_err = 0;
  int n_chk = 0;
  int in_r [N];
  int in_i [N];
  int exp_r[N];
  int exp_i[N];
  int got_r[N];
  int got_i[N];

  always #5 clk = ~clk;

  fft_radix2_iter #(.N(N), .DW(DW), .TW(TW)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef FFT_IFFT_EN
    .inverse   (inverse),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_last  (out_last),
    .busy      (busy)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int rev4(input int v);
    int r;
    r = 0;
    for (int i = 0; i < L; i++) if (v & (1 << i)) r |= 1 << (L - 1 - i);
    return r;
  endfunction

  // DIT FFT on in_r/in_i, result scaled by 1/N through per-stage halving
  function automatic void model_fft(input bit inv);
    longint ar[N];
    longint ai[N];
    longint wr, wi, tr, ti, xa, ya;
    real    ang;
    real    sc;
    int     half;
    sc = real'((1 << (TW - 1)) - 1);
    for (int n = 0; n < N; n++) begin
      ar[rev4(n)] = in_r[n];
      ai[rev4(n)] = in_i[n];
    end
    for (int size = 2; size <= N; size *= 2) begin
      half = size / 2;
      for (int st = 0; st < N; st += size) begin
        for (int j = 0; j < half; j++) begin
          ang = 2.0 * PI * real'(j * (N / size)) / real'(N);
          wr  = $rtoi($floor($cos(ang) * sc + 0.5));
          wi  = $rtoi($floor($sin(ang) * sc + 0.5));
          if (!inv) wi = -wi;
          tr = (ar[st+j+half] * wr - ai[st+j+half] * wi + (64'sd1 << (TW - 2))) >>> (TW - 1);
          ti = (ar[st+j+half] * wi + ai[st+j+half] * wr + (64'sd1 << (TW - 2))) >>> (TW - 1);
          xa = ar[st+j];
          ya = ai[st+j];
          ar[st+j]      = (xa + tr) >>> 1;
          ai[st+j]      = (ya + ti) >>> 1;
          ar[st+j+half] = (xa - tr) >>> 1;
          ai[st+j+half] = (ya - ti) >>> 1;
        end
      end
    end
    for (int k = 0; k < N; k++) begin
      exp_r[k] = int'(ar[k]);
      exp_i[k] = int'(ai[k]);
    end
  endfunction

  task automatic send_frame(input int gap_pct, input bit inv);
    int n;
    int guard;
    bit acc;
    n = 0;
    guard = 0;
    while (n < N && guard < 1000) begin
      @(negedge clk);
      guard++;
      if ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        in_re    = DW'($urandom);
        in_im    = DW'($urandom);
      end else begin
        in_valid = 1'b1;
        in_re    = DW'(in_r[n]);
        in_im    = DW'(in_i[n]);
      end
`ifdef FFT_IFFT_EN
      inverse = (n == 0) ? inv : ~inv;
`else
      if (inv) $display("note: inverse requested without FFT_IFFT_EN");
`endif
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) n++;
    end
    check("send_done", n, N);
  endtask

  // counts edges from last accepted sample to out_valid; in_valid is
  // driven with junk meanwhile, which the DUT must ignore
  task automatic wait_first_out(input string tag);
    int lat;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) begin
        in_valid = 1'b1;
        in_re    = DW'($urandom);
        in_im    = DW'($urandom);
      end
      if (lat == 3) begin
        check("busy_compute", busy, 1);
        check("in_ready_compute", in_ready, 0);
        check("out_valid_compute", out_valid, 0);
      end
    end while (!out_valid && lat < 500);
    check(tag, lat, LAT);
  endtask

  task automatic recv_frame(input int ready_pct);
    int k;
    int guard;
    bit held;
    logic signed [DW-1:0] h_re, h_im;
    logic h_last;
    k = 0;
    guard = 0;
    held = 1'b0;
    h_re = '0;
    h_im = '0;
    h_last = 1'b0;
    while (k < N && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (held) begin
        check("hold_valid", out_valid, 1);
        check("hold_re", out_re, h_re);
        check("hold_im", out_im, h_im);
        check("hold_last", out_last, h_last);
      end
      check("in_ready_unload", in_ready, 0);
      out_ready = ($urandom_range(99) < ready_pct);
      held = 1'b0;
      if (out_valid && out_ready) begin
        got_r[k] = int'(out_re);
        got_i[k] = int'(out_im);
        check($sformatf("bin%0d_re", k), out_re, exp_r[k]);
        check($sformatf("bin%0d_im", k), out_im, exp_i[k]);
        check($sformatf("bin%0d_last", k), out_last, (k == N - 1));
        k++;
        if (k == N) in_valid = 1'b0;
      end else if (out_valid) begin
        held   = 1'b1;
        h_re   = out_re;
        h_im   = out_im;
        h_last = out_last;
      end
    end
    check("recv_done", k, N);
    @(negedge clk);
    out_ready = 1'b0;
    check("in_ready_back", in_ready, 1);
    check("out_valid_idle", out_valid, 0);
    check("busy_idle", busy, 0);
  endtask

  task automatic random_frame();
    for (int n = 0; n < N; n++) begin
      in_r[n] = int'($urandom_range(8000)) - 4000;
      in_i[n] = int'($urandom_range(8000)) - 4000;
    end
    model_fft(1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    real ideal_r, ideal_i, d;
    in_valid  = 1'b0;
    in_re     = '0;
    in_im     = '0;
    out_ready = 1'b0;
`ifdef FFT_IFFT_EN
    inverse   = 1'b0;
`endif
    rst = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_out_re", out_re, 0);
    check("rst_out_im", out_im, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b1;

    // impulse at x[0]: every bin 1000/2/2/2/2 with floor = 62
    for (int n = 0; n < N; n++) begin
      in_r[n]  = (n == 0) ? 1000 : 0;
      in_i[n]  = 0;
      exp_r[n] = 62;
      exp_i[n] = 0;
    end
    send_frame(0, 1'b0);
    wait_first_out("lat_impulse");
    recv_frame(100);

    // constant input: all energy in X[0]
    for (int n = 0; n < N; n++) begin
      in_r[n]  = 1000;
      in_i[n]  = 0;
      exp_r[n] = (n == 0) ? 1000 : 0;
      exp_i[n] = 0;
    end
    send_frame(20, 1'b0);
    wait_first_out("lat_const");
    recv_frame(50);

    // single-tone cosine, bins 1 and 15 near 4000
    for (int n = 0; n < N; n++) begin
      in_r[n] = $rtoi($floor(8000.0 * $cos(2.0 * PI * real'(n) / real'(N)) + 0.5));
      in_i[n] = 0;
    end
    model_fft(1'b0);
    send_frame(30, 1'b0);
    wait_first_out("lat_cos");
    recv_frame(50);
    check("cos_x1_near", ((got_r[1] - 4000) <= 4) && ((got_r[1] - 4000) >= -4), 1);
    check("cos_x15_near", ((got_r[15] - 4000) <= 4) && ((got_r[15] - 4000) >= -4), 1);

    for (int f = 0; f < 3; f++) begin
      random_frame();
      send_frame(25, 1'b0);
      wait_first_out("lat_rand");
      recv_frame(50);
    end

    // reset while butterflies of the third stage are in flight
    random_frame();
    send_frame(0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (24) @(posedge clk);
    #2;
    check("pre_rst_busy", busy, 1);
    rst = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    random_frame();
    send_frame(10, 1'b0);
    wait_first_out("lat_after_rst");
    recv_frame(60);

`ifdef FFT_IFFT_EN
    // inverse impulse at x[1]: X[k] = 62.5 * e^(+j*2*pi*k/16)
    for (int n = 0; n < N; n++) begin
      in_r[n] = (n == 1) ? 1000 : 0;
      in_i[n] = 0;
    end
    model_fft(1'b1);
    send_frame(0, 1'b1);
    wait_first_out("lat_ifft");
    recv_frame(100);
    for (int k = 0; k < N; k++) begin
      ideal_r = 62.5 * $cos(2.0 * PI * real'(k) / real'(N));
      ideal_i = 62.5 * $sin(2.0 * PI * real'(k) / real'(N));
      d = real'(got_r[k]) - ideal_r;
      check($sformatf("ifft_re_tol%0d", k), (d <= 2.0) && (d >= -2.0), 1);
      d = real'(got_i[k]) - ideal_i;
      check($sformatf("ifft_im_tol%0d", k), (d <= 2.0) && (d >= -2.0), 1);
    end
    random_frame();
    send_frame(20, 1'b0);
    wait_first_out("lat_fwd_after_ifft");
    recv_frame(50);
`else
    ideal_r = 0.0;
    ideal_i = 0.0;
    d = ideal_r + ideal_i;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
